// File: rtl/input_pkg.sv
// Shared constants and types for the push-button input controller.
package input_pkg;

  // Default filtering and auto-repeat timing, in sample ticks.
  localparam int DEBOUNCE_TICKS_DEF = 4;
  localparam int REPEAT_DELAY_DEF   = 8;
  localparam int REPEAT_RATE_DEF    = 2;

  // Button channel indices on btn_raw and the output vectors.
  localparam int BTN_FIRE  = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 2;
  localparam int BTN_START = 3;

  // Auto-repeat state per channel.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } repeat_state_t;

  // Larger of two integers, used to size the shared repeat tick counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchronizer, tick-gated debounce, press/release
// pulses and an auto-repeat FSM.
module button_channel
  import input_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int REPEAT_DELAY   = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE    = REPEAT_RATE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_sample,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int DB_W = $clog2(DEBOUNCE_TICKS);
  localparam int RC_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [RC_W-1:0] DELAY_N = RC_W'(REPEAT_DELAY);
  localparam logic [RC_W-1:0] RATE_N  = RC_W'(REPEAT_RATE);

  logic            meta;
  logic            sync;
  logic [DB_W-1:0] db_cnt;
  logic [DB_W-1:0] db_cnt_next;
  logic            level_next;
  logic            accept;
  logic            press_next;
  logic            release_next;

  repeat_state_t   state;
  repeat_state_t   state_next;
  logic [RC_W-1:0] rcnt;
  logic [RC_W-1:0] rcnt_next;
  logic [RC_W-1:0] rcnt_inc;
  logic            repeat_next;

  // Bring the asynchronous pin level into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= btn_raw;
      sync <= meta;
    end
  end

  // Debounce: a level change is accepted after DEBOUNCE_TICKS consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    db_cnt_next = db_cnt;
    level_next  = btn_level;
    accept      = 1'b0;
    if (clk_sample) begin
      if (sync == btn_level) begin
        db_cnt_next = '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt_next = '0;
        level_next  = ~btn_level;
        accept      = 1'b1;
      end else begin
        db_cnt_next = db_cnt + 1'b1;
      end
    end
  end

  assign press_next   = accept & ~btn_level;
  assign release_next = accept &  btn_level;

  // Register the debounced level together with its edge pulses so both
  // become visible in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      db_cnt      <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      db_cnt      <= db_cnt_next;
      btn_level   <= level_next;
      btn_press   <= press_next;
      btn_release <= release_next;
    end
  end

  assign rcnt_inc = rcnt + 1'b1;

  // Auto-repeat next state: pulse on press, after REPEAT_DELAY ticks, then
  // every REPEAT_RATE ticks; a release always wins over a due repeat.
  always_comb begin
    state_next  = state;
    rcnt_next   = rcnt;
    repeat_next = 1'b0;
    case (state)
      IDLE: begin
        if (press_next) begin
          repeat_next = 1'b1;
          rcnt_next   = '0;
          state_next  = DELAY;
        end
      end
      DELAY: begin
        if (release_next) begin
          rcnt_next  = '0;
          state_next = IDLE;
        end else if (clk_sample) begin
          if (rcnt_inc == DELAY_N) begin
            repeat_next = 1'b1;
            rcnt_next   = '0;
            state_next  = REPEAT;
          end else begin
            rcnt_next = rcnt_inc;
          end
        end
      end
      REPEAT: begin
        if (release_next) begin
          rcnt_next  = '0;
          state_next = IDLE;
        end else if (clk_sample) begin
          if (rcnt_inc == RATE_N) begin
            repeat_next = 1'b1;
            rcnt_next   = '0;
          end else begin
            rcnt_next = rcnt_inc;
          end
        end
      end
      default: begin
        rcnt_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Auto-repeat state register and registered repeat pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      rcnt       <= '0;
      btn_repeat <= 1'b0;
    end else begin
      state      <= state_next;
      rcnt       <= rcnt_next;
      btn_repeat <= repeat_next;
    end
  end

endmodule

// File: rtl/button_inputs.sv
// Debounced, edge-detecting controller for the game push buttons; one
// independent channel per button.
module button_inputs
  import input_pkg::*;
#(
  parameter int N_BUTTONS      = 4,
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int REPEAT_DELAY   = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE    = REPEAT_RATE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_sample,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release,
  output logic [N_BUTTONS-1:0] btn_repeat
);

  for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_chan
    button_channel #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_RATE   (REPEAT_RATE)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .clk_sample (clk_sample),
      .btn_raw    (btn_raw[gi]),
      .btn_level  (btn_level[gi]),
      .btn_press  (btn_press[gi]),
      .btn_release(btn_release[gi]),
      .btn_repeat (btn_repeat[gi])
    );
  end

endmodule
